// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD operand feeder and its datapath neighbours:
// the feeder state encoding, response status codes and the core operand width.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_A    = 3'd1,
        S_LOAD_B    = 3'd2,
        S_WAIT_CLR  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_RESP      = 3'd5
    } gcd_feed_state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ZERO    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

endpackage

// File: rtl/gcd_cycle_counter.sv
// Saturating up-counter with synchronous clear and enable. o_tc flags the
// cycle in which the TIMEOUT-th counted cycle is in progress.
module gcd_cycle_counter #(
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // Count register: clear has priority, increments stop at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count >= TC_VAL);

endmodule

// File: rtl/gcd_operand_feeder.sv
// Initiator for the GCD core's start/data_in/done load interface: accepts an
// operand pair, sequences A then B, waits for done and returns a response.
module gcd_operand_feeder
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             start,
    output logic [WIDTH-1:0] data_in,
    input  logic             done,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [1:0]       resp_status,
    output logic [CNT_W-1:0] resp_cycles,
    output logic             busy
);

    localparam int RESP_TC = (1 << CNT_W) - 1;

    gcd_feed_state_t  r_state;
    logic             r_in_ready;
    logic             r_start;
    logic [WIDTH-1:0] r_data_in;
    logic [WIDTH-1:0] r_op_b;
    logic             r_resp_valid;
    logic [1:0]       r_resp_status;
    logic [CNT_W-1:0] r_resp_cycles;
    logic             r_busy;

    logic             w_accept;
    logic             w_zero;
    logic             w_in_wait;
    logic             w_wait_clr;
    logic             w_wait_tc;
    logic             w_resp_en;
    logic             w_resp_tc;
    logic [CNT_W-1:0] w_resp_count;
    logic [CNT_W-1:0] w_resp_next;
    logic [CNT_W-1:0] w_unused_wait_count;

    assign w_accept   = (r_state == S_IDLE) && in_valid && r_in_ready;
    assign w_zero     = (op_a == '0) || (op_b == '0);
    assign w_in_wait  = (r_state == S_WAIT_CLR) || (r_state == S_WAIT_DONE);
    assign w_resp_en  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B) || w_in_wait;
    // Each wait state gets a fresh timeout window.
    assign w_wait_clr = (r_state == S_LOAD_B) || ((r_state == S_WAIT_CLR) && !done);
    // Resp counter holds cycles completed before the current one; add this cycle.
    assign w_resp_next = w_resp_tc ? {CNT_W{1'b1}} : (w_resp_count + CNT_W'(1));

    gcd_cycle_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_wait_clr),
        .i_en    (w_in_wait),
        .o_count (w_unused_wait_count),
        .o_tc    (w_wait_tc)
    );

    gcd_cycle_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (RESP_TC)
    ) u_resp_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_accept),
        .i_en    (w_resp_en),
        .o_count (w_resp_count),
        .o_tc    (w_resp_tc)
    );

    // Feeder FSM with all interface outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b1;
            r_start       <= 1'b0;
            r_data_in     <= '0;
            r_op_b        <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_status <= ST_OK;
            r_resp_cycles <= '0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_op_b     <= op_b;
                        if (w_zero) begin
                            // The core never finishes on a zero operand, so answer locally.
                            r_state       <= S_RESP;
                            r_resp_valid  <= 1'b1;
                            r_resp_status <= ST_ZERO;
                            r_resp_cycles <= '0;
                        end else begin
                            r_state   <= S_LOAD_A;
                            r_start   <= 1'b1;
                            r_data_in <= op_a;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_LOAD_A: begin
                    r_state   <= S_LOAD_B;
                    r_start   <= 1'b0;
                    r_data_in <= r_op_b;
                end
                S_LOAD_B: begin
                    r_state <= S_WAIT_CLR;
                end
                S_WAIT_CLR: begin
                    if (!done) begin
                        r_state <= S_WAIT_DONE;
                    end else if (w_wait_tc) begin
                        r_state       <= S_RESP;
                        r_data_in     <= '0;
                        r_resp_valid  <= 1'b1;
                        r_resp_status <= ST_TIMEOUT;
                        r_resp_cycles <= {CNT_W{1'b1}};
                    end
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        r_state       <= S_RESP;
                        r_data_in     <= '0;
                        r_resp_valid  <= 1'b1;
                        r_resp_status <= ST_OK;
                        r_resp_cycles <= w_resp_next;
                    end else if (w_wait_tc) begin
                        r_state       <= S_RESP;
                        r_data_in     <= '0;
                        r_resp_valid  <= 1'b1;
                        r_resp_status <= ST_TIMEOUT;
                        r_resp_cycles <= {CNT_W{1'b1}};
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_in_ready   <= 1'b1;
                    r_start      <= 1'b0;
                    r_data_in    <= '0;
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign start       = r_start;
    assign data_in     = r_data_in;
    assign resp_valid  = r_resp_valid;
    assign resp_status = r_resp_status;
    assign resp_cycles = r_resp_cycles;
    assign busy        = r_busy;

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Scoreboard bench for gcd_operand_feeder with a mock GCD core that raises
// done a programmable number of cycles after start, or holds it high.
module tb_gcd_operand_feeder;

    localparam int WIDTH = 16;
    localparam int CNT_W = 10;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } load_t;

    typedef struct {
        logic [1:0]       st;
        logic [CNT_W-1:0] cyc;
    } resp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             done;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_status;
    logic [CNT_W-1:0] resp_cycles;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    load_t load_q[$];
    resp_t resp_q[$];
    int    start_cnt   = 0;
    int    exp_starts  = 0;
    logic             expect_b = 1'b0;
    logic [WIDTH-1:0] exp_b    = '0;

    logic        done_r     = 1'b0;
    logic        force_done = 1'b0;
    int unsigned mock_cnt   = 0;
    int unsigned mock_n     = 5;

    gcd_operand_feeder #(.WIDTH(WIDTH), .TIMEOUT(1023), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .start       (start),
        .data_in     (data_in),
        .done        (done),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_status (resp_status),
        .resp_cycles (resp_cycles),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Mock core: start clears done, which rises mock_n+1 cycles after start.
    always @(posedge clk) begin
        if (start) begin
            done_r   <= 1'b0;
            mock_cnt <= 1;
        end else if (mock_cnt != 0) begin
            if (mock_cnt >= mock_n) begin
                done_r   <= 1'b1;
                mock_cnt <= 0;
            end else begin
                mock_cnt <= mock_cnt + 1;
            end
        end
    end

    assign done = force_done | done_r;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: load order on the core bus and response scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            expect_b <= 1'b0;
        end else begin
            if (expect_b) begin
                check_eq("start_width", start, 0);
                check_eq("data_b", data_in, exp_b);
                expect_b <= 1'b0;
            end
            if (start && !expect_b) begin
                start_cnt <= start_cnt + 1;
                check_eq("start_expected", (load_q.size() > 0), 1);
                if (load_q.size() > 0) begin
                    load_t l;
                    l = load_q.pop_front();
                    check_eq("data_a", data_in, l.a);
                    exp_b    <= l.b;
                    expect_b <= 1'b1;
                end
            end
            if (resp_valid && resp_ready) begin
                check_eq("resp_expected", (resp_q.size() > 0), 1);
                if (resp_q.size() > 0) begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check_eq("resp_status", resp_status, r.st);
                    check_eq("resp_cycles", resp_cycles, r.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input int delay, input bit hold);
        int    n;
        resp_t r;
        n = 0;
        while (!in_ready && n < 3000) begin
            step();
            n++;
        end
        check_eq("in_ready_wait", in_ready, 1);
        if (a == 0 || b == 0) begin
            r.st  = 2'd1;
            r.cyc = '0;
        end else begin
            load_q.push_back('{a: a, b: b});
            exp_starts++;
            if (hold) begin
                r.st  = 2'd2;
                r.cyc = {CNT_W{1'b1}};
            end else begin
                r.st  = 2'd0;
                r.cyc = CNT_W'(delay + 1);
            end
        end
        resp_q.push_back(r);
        mock_n   = (delay > 1) ? (delay - 1) : 1;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((resp_q.size() != 0 || !in_ready) && n < budget) begin
            step();
            n++;
        end
        check_eq("resp_wait", resp_q.size(), 0);
    endtask

    initial begin
        int s0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        resp_ready = 1'b1;
        repeat (3) step();
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_start", start, 0);
        check_eq("rst_data_in", data_in, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_status", resp_status, 0);
        check_eq("rst_resp_cycles", resp_cycles, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // Basic pair, done 6 cycles after start.
        send_pair(16'd48, 16'd18, 6, 1'b0);
        check_eq("t1_busy", busy, 1);
        wait_idle(200);

        // Zero operand: immediate response, no start.
        s0 = exp_starts;
        send_pair(16'd0, 16'd25, 0, 1'b0);
        check_eq("t2_resp_valid", resp_valid, 1);
        check_eq("t2_status_now", resp_status, 1);
        wait_idle(50);
        check_eq("t2_no_start", start_cnt, s0);

        // done stuck high: WAIT_CLR times out.
        force_done = 1'b1;
        send_pair(16'd5, 16'd3, 0, 1'b1);
        wait_idle(1500);
        force_done = 1'b0;
        step();

        // Response back-pressure with ignored in_valid pulses.
        resp_ready = 1'b0;
        s0 = exp_starts;
        send_pair(16'd9, 16'd6, 3, 1'b0);
        for (int i = 0; i < 100 && !resp_valid; i++) step();
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_valid_hold", resp_valid, 1);
            check_eq("t4_status_hold", resp_status, 0);
            check_eq("t4_cycles_hold", resp_cycles, 4);
            check_eq("t4_in_ready_low", in_ready, 0);
            op_a     = 16'd1;
            op_b     = 16'd1;
            in_valid = (i % 2 == 0);
            step();
        end
        in_valid   = 1'b0;
        resp_ready = 1'b1;
        wait_idle(50);
        check_eq("t4_single_start", start_cnt, s0 + 1);

        // Reset while waiting for done discards the operation.
        send_pair(16'd11, 16'd4, 6, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        resp_q.delete();
        load_q.delete();
        check_eq("t5_busy", busy, 0);
        check_eq("t5_in_ready", in_ready, 1);
        check_eq("t5_resp_valid", resp_valid, 0);
        check_eq("t5_start", start, 0);
        check_eq("t5_data_in", data_in, 0);
        rst = 1'b0;
        repeat (6) step();
        send_pair(16'd7, 16'd7, 6, 1'b0);
        wait_idle(200);

        // Back-to-back pairs with resp_ready tied high.
        s0 = start_cnt;
        send_pair(16'd21, 16'd14, 4, 1'b0);
        send_pair(16'd100, 16'd75, 5, 1'b0);
        wait_idle(200);
        check_eq("t6_two_starts", start_cnt, s0 + 2);
        check_eq("total_starts", start_cnt, exp_starts);
        check_eq("load_q_empty", load_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
